id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register that executes the hazard unit's stall and flush decisions.
//  - Loads decoded ID fields into EX.
//  - Holds them on hold_i.
//  - Replaces them with a NOP bubble on flush_i.
//  - Tracks consecutive-hold length and raises a sticky watchdog flag when a hold runs too long.
//  Sits between the decoder/regfile read (ID) and the ALU/NPC logic (EX) of the 5-stage core.
// PARAMETERS
//  CNT_W     5    width of consecutive-hold counter hold_cnt
//  MAX_HOLD  8    hold_timeout sets when hold_cnt reaches this value (must be < 2**CNT_W)
// PORTS
//  clk           in   1   core clock, rising edge
//  rst           in   1   reset
//  hold_i        in   1   keep current EX contents (freeze)
//  flush_i       in   1   load bubble into EX
//  id_valid      in   1   ID slot holds a real instruction
//  id_pc         in   32  PC of ID instruction
//  id_inst       in   32  instruction word
//  id_rd1        in   32  rs1 read data
//  id_rd2        in   32  rs2 read data
//  id_ext        in   32  sign-extended immediate
//  id_we         in   1   regfile write enable
//  id_wr         in   5   destination register
//  id_npc_op     in   3   NPC op (NPC_PC4/JMP/BEQ/BNE/BLT/BGE)
//  ex_valid/ex_pc/ex_inst/ex_rd1/ex_rd2/ex_ext/ex_we/ex_wr/ex_npc_op  out  same widths  registered EX copies
//  hold_cnt      out  CNT_W   consecutive cycles spent in HOLD, saturating
//  hold_timeout  out  1   sticky: hold lasted MAX_HOLD cycles
// BEHAVIOUR
//  - Reset is rst, synchronous, active-high.
//    - All ex_* outputs take bubble values.
//    - hold_cnt=0, hold_timeout=0, state=RUN.
//  - Bubble values: ex_valid=0, ex_we=0, ex_wr=0, ex_npc_op=NPC_PC4, ex_inst=32'h0000_0013 (addi x0,x0,0).
//    All other ex_* fields are 0.
//  - Priority at each rising edge: rst > flush_i > hold_i > load.
//    - flush_i: bubble loaded regardless of hold_i. Next state RUN. hold_cnt cleared.
//    - hold_i (no flush): every ex_* register unchanged.
//    - Otherwise: all ex_* <= id_* in one cycle (latency 1).
//      If id_valid=0, the bubble is loaded instead, so ex_we can never be 1 with ex_valid=0.
//  - FSM, 2 states:
//    - RUN:  hold_i & ~flush_i -> HOLD (hold_cnt <= 1). Otherwise stay.
//    - HOLD: hold_i & ~flush_i -> HOLD (hold_cnt += 1, saturates at 2**CNT_W-1).
//            flush_i or ~hold_i -> RUN (hold_cnt <= 0).
//  - hold_timeout sets on the edge where hold_cnt becomes MAX_HOLD.
//    Only rst clears it; flush does not.
//  - Boundary cases:
//    - hold_i on a bubble keeps the bubble and still counts.
//    - Reset during HOLD drops the held instruction (bubble).
//    - hold_cnt never wraps.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  ID_EX_PERF_CNT_EN defined: adds two outputs.
//    - perf_bubbles [31:0]: edges where a bubble was loaded by flush_i or id_valid=0.
//    - perf_holds [31:0]: edges with hold_i & ~flush_i.
//    - Both are saturating at 32'hFFFF_FFFF and cleared by rst.
//  ID_EX_PERF_CNT_EN undefined: both ports and counters are absent. No other behaviour change.
// TESTING
//  1. rst=1 one cycle with id_* nonzero.
//     -> ex_valid=0, ex_inst=32'h13, ex_we=0, ex_npc_op=NPC_PC4, hold_cnt=0, hold_timeout=0.
//  2. id_valid=1, id_pc=32'h100, id_wr=5, id_we=1, no hold/flush.
//     -> next cycle ex_pc=32'h100, ex_wr=5, ex_we=1, ex_valid=1.
//  3. After case 2, hold_i=1 for 3 cycles while id_pc=32'h104.
//     -> ex_pc stays 32'h100; hold_cnt 1,2,3; release -> ex_pc=32'h104, hold_cnt=0.
//  4. hold_i=1 and flush_i=1 together.
//     -> bubble loaded (ex_valid=0, ex_we=0), state RUN, hold_cnt=0.
//  5. hold_i=1 for 10 cycles, MAX_HOLD=8.
//     -> hold_timeout=1 from the 8th edge; stays 1 after release and after flush; only rst clears it.
//  6. ID_EX_PERF_CNT_EN defined: 2 flushes plus 1 id_valid=0 load, and 4 hold cycles.
//     -> perf_bubbles=3, perf_holds=4.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: load, hold (freeze), flush (bubble), with a consecutive-hold counter
// and a sticky hold watchdog. Define ID_EX_PERF_CNT_EN to add bubble/hold performance counters.
module id_ex_stage_reg #(
   parameter int CNT_W    = 5,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic             id_valid,
   input  logic [31:0]      id_pc,
   input  logic [31:0]      id_inst,
   input  logic [31:0]      id_rd1,
   input  logic [31:0]      id_rd2,
   input  logic [31:0]      id_ext,
   input  logic             id_we,
   input  logic [4:0]       id_wr,
   input  logic [2:0]       id_npc_op,
   output logic             ex_valid,
   output logic [31:0]      ex_pc,
   output logic [31:0]      ex_inst,
   output logic [31:0]      ex_rd1,
   output logic [31:0]      ex_rd2,
   output logic [31:0]      ex_ext,
   output logic             ex_we,
   output logic [4:0]       ex_wr,
   output logic [2:0]       ex_npc_op,
   output logic [CNT_W-1:0] hold_cnt,
   output logic             hold_timeout
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0]      perf_bubbles,
   output logic [31:0]      perf_holds
`endif
);

   localparam logic [2:0]       NPC_PC4  = 3'd0;
   localparam logic [31:0]      NOP_INST = 32'h0000_0013;
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(MAX_HOLD);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
      logic        we;
      logic [4:0]  wr;
      logic [2:0]  npc_op;
   } ex_t;

   localparam ex_t BUBBLE = '{1'b0, 32'h0, NOP_INST, 32'h0, 32'h0, 32'h0, 1'b0, 5'h0, NPC_PC4};

   typedef enum logic {RUN, HOLD} state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] next_cnt;
   ex_t              ex_q, id_fields;
   logic             do_hold;

   assign id_fields = '{id_valid, id_pc, id_inst, id_rd1, id_rd2, id_ext, id_we, id_wr, id_npc_op};
   assign do_hold   = hold_i & ~flush_i;

   // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      next_cnt   = '0;
      case (state)
         RUN: begin
            if (do_hold) begin
               next_state = HOLD;
               next_cnt   = CNT_W'(1);
            end
         end
         HOLD: begin
            if (do_hold)
               next_cnt = (hold_cnt == CNT_SAT) ? hold_cnt : hold_cnt + CNT_W'(1);
            else
               next_state = RUN;
         end
         default: next_state = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         hold_cnt     <= '0;
         hold_timeout <= 1'b0;
      end else begin
         state    <= next_state;
         hold_cnt <= next_cnt;
         if (next_cnt == CNT_LIM)
            hold_timeout <= 1'b1;
      end
   end

   // A non-valid ID slot becomes a bubble so ex_we can never be set without ex_valid.
   always_ff @(posedge clk) begin
      if (rst || flush_i)
         ex_q <= BUBBLE;
      else if (!hold_i)
         ex_q <= id_valid ? id_fields : BUBBLE;
   end

   assign ex_valid  = ex_q.valid;
   assign ex_pc     = ex_q.pc;
   assign ex_inst   = ex_q.inst;
   assign ex_rd1    = ex_q.rd1;
   assign ex_rd2    = ex_q.rd2;
   assign ex_ext    = ex_q.ext;
   assign ex_we     = ex_q.we;
   assign ex_wr     = ex_q.wr;
   assign ex_npc_op = ex_q.npc_op;

`ifdef ID_EX_PERF_CNT_EN
   logic bubble_load;
   assign bubble_load = flush_i | (~hold_i & ~id_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubbles <= '0;
         perf_holds   <= '0;
      end else begin
         if (bubble_load && perf_bubbles != 32'hFFFF_FFFF)
            perf_bubbles <= perf_bubbles + 32'd1;
         if (do_hold && perf_holds != 32'hFFFF_FFFF)
            perf_holds <= perf_holds + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed vector table, hand-written corner sequences,
// and randomized stimulus against a behavioural model of the stall/flush rules.
module tb_id_ex_stage_reg;
   localparam int CNT_W    = 5;
   localparam int MAX_HOLD = 8;
   localparam int CNT_SAT  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, hold_i, flush_i, id_valid, id_we;
   logic [31:0]      id_pc, id_inst, id_rd1, id_rd2, id_ext;
   logic [4:0]       id_wr;
   logic [2:0]       id_npc_op;
   logic             ex_valid, ex_we;
   logic [31:0]      ex_pc, ex_inst, ex_rd1, ex_rd2, ex_ext;
   logic [4:0]       ex_wr;
   logic [2:0]       ex_npc_op;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_timeout;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0]      perf_bubbles, perf_holds;
`endif

   always #5 clk = ~clk;

   id_ex_stage_reg #(.CNT_W(CNT_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i), .id_valid(id_valid),
      .id_pc(id_pc), .id_inst(id_inst), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_ext(id_ext),
      .id_we(id_we), .id_wr(id_wr), .id_npc_op(id_npc_op),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_ext(ex_ext), .ex_we(ex_we), .ex_wr(ex_wr), .ex_npc_op(ex_npc_op),
      .hold_cnt(hold_cnt), .hold_timeout(hold_timeout)
`ifdef ID_EX_PERF_CNT_EN
      , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, inst, rd1, rd2, ext;
      logic        we;
      logic [4:0]  wr;
      logic [2:0]  npc_op;
   } rec_t;

   // Reference model: EX contents, length of the current hold run, sticky flag, event counts.
   rec_t   m_ex;
   int     m_run;
   bit     m_to;
   longint m_pb, m_ph;

   function automatic rec_t bubble();
      rec_t b = '0;
      b.inst = 32'h0000_0013;
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_edge();
      if (rst) begin
         m_ex = bubble(); m_run = 0; m_to = 0; m_pb = 0; m_ph = 0;
      end else if (flush_i) begin
         m_ex = bubble(); m_run = 0;
         if (m_pb < 64'hFFFF_FFFF) m_pb++;
      end else if (hold_i) begin
         if (m_run < 100000) m_run++;
         if (m_ph < 64'hFFFF_FFFF) m_ph++;
      end else begin
         m_run = 0;
         if (id_valid)
            m_ex = '{id_valid, id_pc, id_inst, id_rd1, id_rd2, id_ext, id_we, id_wr, id_npc_op};
         else begin
            m_ex = bubble();
            if (m_pb < 64'hFFFF_FFFF) m_pb++;
         end
      end
      if (m_run >= MAX_HOLD) m_to = 1;
   endtask

   task automatic cmp_all(input string tag);
      check({tag, ".valid"},  64'(ex_valid),     64'(m_ex.valid));
      check({tag, ".pc"},     64'(ex_pc),        64'(m_ex.pc));
      check({tag, ".inst"},   64'(ex_inst),      64'(m_ex.inst));
      check({tag, ".rd1"},    64'(ex_rd1),       64'(m_ex.rd1));
      check({tag, ".rd2"},    64'(ex_rd2),       64'(m_ex.rd2));
      check({tag, ".ext"},    64'(ex_ext),       64'(m_ex.ext));
      check({tag, ".we"},     64'(ex_we),        64'(m_ex.we));
      check({tag, ".wr"},     64'(ex_wr),        64'(m_ex.wr));
      check({tag, ".npc_op"}, 64'(ex_npc_op),    64'(m_ex.npc_op));
      check({tag, ".cnt"},    64'(hold_cnt),     64'((m_run > CNT_SAT) ? CNT_SAT : m_run));
      check({tag, ".to"},     64'(hold_timeout), 64'(m_to));
`ifdef ID_EX_PERF_CNT_EN
      check({tag, ".pb"},     64'(perf_bubbles), 64'(m_pb));
      check({tag, ".ph"},     64'(perf_holds),   64'(m_ph));
`endif
   endtask

   task automatic drive(input bit r, input bit h, input bit f, input bit v,
                        input logic [31:0] pc, input logic [4:0] wr, input bit we);
      rst = r; hold_i = h; flush_i = f; id_valid = v;
      id_pc = pc; id_inst = 32'h00A0_0000 | pc; id_wr = wr; id_we = we;
      id_rd1 = $urandom; id_rd2 = $urandom; id_ext = $urandom;
      id_npc_op = 3'($urandom_range(0, 5));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      cmp_all(tag);
   endtask

   typedef struct {
      bit          rst, hold, flush, valid;
      logic [31:0] pc;
      logic [4:0]  wr;
      bit          we;
      bit          e_valid;
      logic [31:0] e_pc;
      logic [4:0]  e_wr;
      bit          e_we;
      int          e_cnt;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int burst;
      //           rst hld fls vld pc        wr we  | e_valid e_pc     e_wr e_we cnt
      tbl[0] = '{1, 0, 0, 1, 32'h55,  5'd7, 1,  0, 32'h0,   5'd0, 0, 0};
      tbl[1] = '{0, 0, 0, 1, 32'h100, 5'd5, 1,  1, 32'h100, 5'd5, 1, 0};
      tbl[2] = '{0, 1, 0, 1, 32'h104, 5'd6, 1,  1, 32'h100, 5'd5, 1, 1};
      tbl[3] = '{0, 1, 0, 1, 32'h104, 5'd6, 1,  1, 32'h100, 5'd5, 1, 2};
      tbl[4] = '{0, 1, 0, 1, 32'h104, 5'd6, 1,  1, 32'h100, 5'd5, 1, 3};
      tbl[5] = '{0, 0, 0, 1, 32'h104, 5'd6, 1,  1, 32'h104, 5'd6, 1, 0};
      tbl[6] = '{0, 1, 1, 1, 32'h108, 5'd7, 1,  0, 32'h0,   5'd0, 0, 0};
      tbl[7] = '{0, 1, 0, 1, 32'h10C, 5'd8, 1,  0, 32'h0,   5'd0, 0, 1};
      tbl[8] = '{0, 0, 0, 0, 32'h110, 5'd9, 1,  0, 32'h0,   5'd0, 0, 0};
      tbl[9] = '{0, 0, 0, 1, 32'h114, 5'd3, 0,  1, 32'h114, 5'd3, 0, 0};

      m_ex = bubble(); m_run = 0; m_to = 0; m_pb = 0; m_ph = 0;
      drive(1, 0, 0, 0, 32'h0, 5'd0, 0);
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].rst, tbl[i].hold, tbl[i].flush, tbl[i].valid, tbl[i].pc, tbl[i].wr, tbl[i].we);
         step($sformatf("vec%0d", i));
         check($sformatf("vec%0d.t_valid", i), 64'(ex_valid), 64'(tbl[i].e_valid));
         check($sformatf("vec%0d.t_pc", i),    64'(ex_pc),    64'(tbl[i].e_pc));
         check($sformatf("vec%0d.t_wr", i),    64'(ex_wr),    64'(tbl[i].e_wr));
         check($sformatf("vec%0d.t_we", i),    64'(ex_we),    64'(tbl[i].e_we));
         check($sformatf("vec%0d.t_cnt", i),   64'(hold_cnt), 64'(tbl[i].e_cnt));
         check($sformatf("vec%0d.t_inst", i),  64'(ex_inst),
               tbl[i].e_valid ? 64'(32'h00A0_0000 | tbl[i].e_pc) : 64'h13);
         check($sformatf("vec%0d.t_to", i),    64'(hold_timeout), 64'h0);
      end

      // Watchdog: sets on the 8th consecutive hold edge, survives release and flush.
      drive(1, 0, 0, 0, 32'h0, 5'd0, 0);   step("wd_rst");
      drive(0, 0, 0, 1, 32'h200, 5'd1, 1); step("wd_load");
      for (int i = 1; i <= 10; i++) begin
         drive(0, 1, 0, 1, 32'h204, 5'd2, 1);
         step($sformatf("wd_hold%0d", i));
         check($sformatf("wd_to%0d", i), 64'(hold_timeout), 64'(i >= MAX_HOLD));
         check($sformatf("wd_pc%0d", i), 64'(ex_pc), 64'h200);
      end
      drive(0, 0, 0, 1, 32'h204, 5'd2, 1); step("wd_rel");
      check("wd_to_rel", 64'(hold_timeout), 64'h1);
      check("wd_cnt_rel", 64'(hold_cnt), 64'h0);
      drive(0, 0, 1, 1, 32'h208, 5'd3, 1); step("wd_flush");
      check("wd_to_flush", 64'(hold_timeout), 64'h1);

      // Long hold saturates the counter, then reset mid-hold drops the held instruction.
      drive(0, 0, 0, 1, 32'h20C, 5'd4, 1); step("sat_load");
      for (int i = 0; i < 40; i++) begin
         drive(0, 1, 0, 1, 32'h210, 5'd5, 1);
         step("sat_hold");
      end
      check("sat_cnt", 64'(hold_cnt), 64'(CNT_SAT));
      check("sat_pc", 64'(ex_pc), 64'h20C);
      drive(1, 1, 0, 1, 32'h210, 5'd5, 1); step("hold_rst");
      check("hold_rst_valid", 64'(ex_valid), 64'h0);
      check("hold_rst_to", 64'(hold_timeout), 64'h0);
      check("hold_rst_cnt", 64'(hold_cnt), 64'h0);

`ifdef ID_EX_PERF_CNT_EN
      drive(0, 0, 1, 1, 32'h300, 5'd1, 1); step("pc_f1");
      drive(0, 0, 1, 1, 32'h304, 5'd1, 1); step("pc_f2");
      drive(0, 0, 0, 0, 32'h308, 5'd1, 1); step("pc_nv");
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 1, 32'h30C, 5'd1, 1);
         step("pc_h");
      end
      check("perf_bubbles", 64'(perf_bubbles), 64'd3);
      check("perf_holds", 64'(perf_holds), 64'd4);
`endif

      // Randomized traffic with occasional long hold bursts to reach the watchdog.
      burst = 0;
      for (int i = 0; i < 600; i++) begin
         bit r, h, f, v;
         if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(5, 40);
         r = ($urandom_range(0, 99) == 0);
         h = (burst > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
         f = (burst > 0) ? 1'b0 : ($urandom_range(0, 9) == 0);
         v = ($urandom_range(0, 9) < 7);
         if (burst > 0) burst--;
         drive(r, h, f, v, $urandom, 5'($urandom), 1'($urandom));
         id_inst = $urandom;
         step($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
